// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite memory endpoint for the MIPS CPU: word-addressed RAM with byte strobes,
// one outstanding read and one outstanding write, plus wrapping R/B handshake counters.
module axi_lite_mem_slave #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        mips_cpu_clk,
  input  logic        mips_cpu_reset_n,
  input  logic [31:0] axi_araddr,
  input  logic        axi_arvalid,
  output logic        axi_arready,
  output logic [31:0] axi_rdata,
  output logic [1:0]  axi_rresp,
  output logic        axi_rvalid,
  input  logic        axi_rready,
  input  logic [31:0] axi_awaddr,
  input  logic        axi_awvalid,
  output logic        axi_awready,
  input  logic [31:0] axi_wdata,
  input  logic [3:0]  axi_wstrb,
  input  logic        axi_wvalid,
  output logic        axi_wready,
  output logic [1:0]  axi_bresp,
  output logic        axi_bvalid,
  input  logic        axi_bready,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt
);

  localparam int          DEPTH       = 1 << ADDR_WIDTH;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  function automatic logic addr_in_range(input logic [31:0] addr);
    addr_in_range = (addr[31:ADDR_WIDTH+2] == '0);
  endfunction

  function automatic logic [31:0] strobe_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  strb);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) begin
        res[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    strobe_merge = res;
  endfunction

  logic [31:0] mem_q [0:DEPTH-1];

  logic        live_q,   live_d;
  logic        aw_got_q, aw_got_d;
  logic        w_got_q,  w_got_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic [31:0] wdata_q,  wdata_d;
  logic [3:0]  wstrb_q,  wstrb_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q,  bresp_d;
  logic        rvalid_q, rvalid_d;
  logic [1:0]  rresp_q,  rresp_d;
  logic [31:0] rdata_q,  rdata_d;
  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;

  logic                  aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s, commit_s;
  logic [31:0]           wr_addr_s, wr_data_s;
  logic [3:0]            wr_strb_s;
  logic                  wr_in_range_s, rd_in_range_s;
  logic [ADDR_WIDTH-1:0] wr_idx_s, rd_idx_s;
  logic                  unused_s;

  assign axi_awready = live_q & ~aw_got_q & ~bvalid_q;
  assign axi_wready  = live_q & ~w_got_q & ~bvalid_q;
  assign axi_arready = live_q & ~rvalid_q;

  assign aw_hs_s  = axi_awvalid & axi_awready;
  assign w_hs_s   = axi_wvalid & axi_wready;
  assign b_hs_s   = bvalid_q & axi_bready;
  assign ar_hs_s  = axi_arvalid & axi_arready;
  assign r_hs_s   = rvalid_q & axi_rready;
  assign commit_s = (aw_got_q | aw_hs_s) & (w_got_q | w_hs_s);

  // The channel handshaking on the commit edge overrides its latched copy.
  assign wr_addr_s     = aw_hs_s ? axi_awaddr : awaddr_q;
  assign wr_data_s     = w_hs_s ? axi_wdata : wdata_q;
  assign wr_strb_s     = w_hs_s ? axi_wstrb : wstrb_q;
  assign wr_in_range_s = addr_in_range(wr_addr_s);
  assign wr_idx_s      = wr_addr_s[ADDR_WIDTH+1:2];
  assign rd_in_range_s = addr_in_range(axi_araddr);
  assign rd_idx_s      = axi_araddr[ADDR_WIDTH+1:2];
  assign unused_s      = ^{axi_araddr[1:0], wr_addr_s[1:0]};

  // Next-state logic for the write and read channels and the counters.
  always_comb begin
    live_d   = 1'b1;
    aw_got_d = aw_got_q;
    w_got_d  = w_got_q;
    awaddr_d = aw_hs_s ? axi_awaddr : awaddr_q;
    wdata_d  = w_hs_s ? axi_wdata : wdata_q;
    wstrb_d  = w_hs_s ? axi_wstrb : wstrb_q;
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    wr_cnt_d = wr_cnt_q;
    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    rd_cnt_d = rd_cnt_q;

    if (commit_s) begin
      aw_got_d = 1'b0;
      w_got_d  = 1'b0;
      bvalid_d = 1'b1;
      bresp_d  = wr_in_range_s ? RESP_OKAY : RESP_SLVERR;
    end else begin
      aw_got_d = aw_got_q | aw_hs_s;
      w_got_d  = w_got_q | w_hs_s;
      if (b_hs_s) begin
        bvalid_d = 1'b0;
        wr_cnt_d = wr_cnt_q + 32'd1;
      end else begin
        bvalid_d = bvalid_q;
      end
    end

    if (ar_hs_s) begin
      rvalid_d = 1'b1;
      rresp_d  = rd_in_range_s ? RESP_OKAY : RESP_SLVERR;
      rdata_d  = rd_in_range_s ? mem_q[rd_idx_s] : 32'h0000_0000;
    end else if (r_hs_s) begin
      rvalid_d = 1'b0;
      rd_cnt_d = rd_cnt_q + 32'd1;
    end else begin
      rvalid_d = rvalid_q;
    end
  end

  // Control and response registers.
  always_ff @(posedge mips_cpu_clk or negedge mips_cpu_reset_n) begin
    if (!mips_cpu_reset_n) begin
      live_q   <= 1'b0;
      aw_got_q <= 1'b0;
      w_got_q  <= 1'b0;
      awaddr_q <= 32'h0000_0000;
      wdata_q  <= 32'h0000_0000;
      wstrb_q  <= 4'b0000;
      bvalid_q <= 1'b0;
      bresp_q  <= 2'b00;
      wr_cnt_q <= 32'h0000_0000;
      rvalid_q <= 1'b0;
      rresp_q  <= 2'b00;
      rdata_q  <= 32'h0000_0000;
      rd_cnt_q <= 32'h0000_0000;
    end else begin
      live_q   <= live_d;
      aw_got_q <= aw_got_d;
      w_got_q  <= w_got_d;
      awaddr_q <= awaddr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      bvalid_q <= bvalid_d;
      bresp_q  <= bresp_d;
      wr_cnt_q <= wr_cnt_d;
      rvalid_q <= rvalid_d;
      rresp_q  <= rresp_d;
      rdata_q  <= rdata_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  // RAM write port; contents are deliberately not reset.
  always_ff @(posedge mips_cpu_clk) begin
    if (commit_s && wr_in_range_s) begin
      mem_q[wr_idx_s] <= strobe_merge(mem_q[wr_idx_s], wr_data_s, wr_strb_s);
    end
  end

  assign axi_bvalid = bvalid_q;
  assign axi_bresp  = bresp_q;
  assign axi_rvalid = rvalid_q;
  assign axi_rresp  = rresp_q;
  assign axi_rdata  = rdata_q;
  assign rd_cnt     = rd_cnt_q;
  assign wr_cnt     = wr_cnt_q;

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// Self-checking bench for axi_lite_mem_slave: directed corner sequences, a constant
// vector table, and randomized traffic against a word-array reference model.
module tb_axi_lite_mem_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] axi_araddr, axi_awaddr, axi_wdata, axi_rdata, rd_cnt, wr_cnt;
  logic        axi_arvalid, axi_arready, axi_rvalid, axi_rready;
  logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready;
  logic        axi_bvalid, axi_bready;
  logic [3:0]  axi_wstrb;
  logic [1:0]  axi_rresp, axi_bresp;

  int checks = 0;
  int errors = 0;
  int exp_rd = 0;
  int exp_wr = 0;
  logic [31:0] ref_mem [0:31];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] init;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
  } vec_t;
  vec_t tbl [7];

  always #5 clk = ~clk;

  axi_lite_mem_slave #(.ADDR_WIDTH(10)) dut (
    .mips_cpu_clk(clk), .mips_cpu_reset_n(rst_n),
    .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid),
    .axi_rready(axi_rready), .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid),
    .axi_awready(axi_awready), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_bresp(axi_bresp),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_aw(input logic [31:0] addr);
    logic hs = 1'b0;
    axi_awaddr  = addr;
    axi_awvalid = 1'b1;
    for (int i = 0; i < 50 && !hs; i++) begin
      @(negedge clk); hs = axi_awready;
      @(posedge clk); #1;
    end
    axi_awvalid = 1'b0;
    chk("aw_handshake", hs, 1);
  endtask

  task automatic do_w(input logic [31:0] data, input logic [3:0] strb);
    logic hs = 1'b0;
    axi_wdata  = data;
    axi_wstrb  = strb;
    axi_wvalid = 1'b1;
    for (int i = 0; i < 50 && !hs; i++) begin
      @(negedge clk); hs = axi_wready;
      @(posedge clk); #1;
    end
    axi_wvalid = 1'b0;
    chk("w_handshake", hs, 1);
  endtask

  task automatic do_ar(input logic [31:0] addr);
    logic hs = 1'b0;
    axi_araddr  = addr;
    axi_arvalid = 1'b1;
    for (int i = 0; i < 50 && !hs; i++) begin
      @(negedge clk); hs = axi_arready;
      @(posedge clk); #1;
    end
    axi_arvalid = 1'b0;
    chk("ar_handshake", hs, 1);
  endtask

  // mode 0: AW and W together; 1: AW first; 2: W first. gap adds idle cycles between.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int mode, input int gap);
    if (mode == 0) begin
      fork
        do_aw(addr);
        do_w(data, strb);
      join
    end else if (mode == 1) begin
      do_aw(addr);
      if (gap > 0) begin repeat (gap) @(posedge clk); #1; end
      do_w(data, strb);
    end else begin
      do_w(data, strb);
      if (gap > 0) begin repeat (gap) @(posedge clk); #1; end
      do_aw(addr);
    end
  endtask

  task automatic wait_b(input logic [1:0] exp_resp, input int delay);
    logic seen = 1'b0;
    int   wait_cyc = 0;
    if (delay > 0) begin repeat (delay) @(posedge clk); #1; end
    axi_bready = 1'b1;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (axi_bvalid) begin
        seen = 1'b1;
        chk("bresp", axi_bresp, exp_resp);
      end else begin
        wait_cyc++;
      end
      @(posedge clk); #1;
    end
    axi_bready = 1'b0;
    chk("b_handshake", seen, 1);
    if (seen) exp_wr++;
    if (delay == 0) chk("b_latency", wait_cyc, 0);
  endtask

  task automatic get_r(input logic [31:0] exp_data, input logic [1:0] exp_resp, input int delay);
    logic seen = 1'b0;
    int   wait_cyc = 0;
    if (delay > 0) begin repeat (delay) @(posedge clk); #1; end
    axi_rready = 1'b1;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (axi_rvalid) begin
        seen = 1'b1;
        chk("rdata", axi_rdata, exp_data);
        chk("rresp", axi_rresp, exp_resp);
      end else begin
        wait_cyc++;
      end
      @(posedge clk); #1;
    end
    axi_rready = 1'b0;
    chk("r_handshake", seen, 1);
    if (seen) exp_rd++;
    if (delay == 0) chk("r_latency", wait_cyc, 0);
  endtask

  initial begin
    logic [31:0] addr, data;
    logic [3:0]  strb;
    logic        inr;
    int          idx;

    tbl[0] = '{32'h0000_0040, 32'h0000_0000, 32'hFFFF_FFFF, 4'b1000, 32'hFF00_0000, 2'b00};
    tbl[1] = '{32'h0000_0044, 32'h1234_5678, 32'hAABB_CCDD, 4'b0000, 32'h1234_5678, 2'b00};
    tbl[2] = '{32'h0000_0048, 32'hFFFF_FFFF, 32'h0000_0000, 4'b0110, 32'hFF00_00FF, 2'b00};
    tbl[3] = '{32'h0000_004F, 32'h0102_0304, 32'hA0B0_C0D0, 4'b0011, 32'h0102_C0D0, 2'b00};
    tbl[4] = '{32'h8000_0050, 32'h7777_7777, 32'h8888_8888, 4'b1111, 32'h0000_0000, 2'b10};
    tbl[5] = '{32'h0000_0FFC, 32'h55AA_55AA, 32'h1111_1111, 4'b1111, 32'h1111_1111, 2'b00};
    tbl[6] = '{32'h0000_1004, 32'h2222_2222, 32'h3333_3333, 4'b1111, 32'h0000_0000, 2'b10};

    rst_n = 1'b0;
    axi_araddr = 32'h0; axi_arvalid = 1'b0; axi_rready = 1'b0;
    axi_awaddr = 32'h0; axi_awvalid = 1'b0; axi_wdata = 32'h0; axi_wstrb = 4'h0;
    axi_wvalid = 1'b0; axi_bready = 1'b0;

    // Reset state, then release: readies 0 for the first cycle, 1 afterwards.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_readies", {axi_arready, axi_awready, axi_wready}, 0);
    chk("rst_valids", {axi_rvalid, axi_bvalid}, 0);
    chk("rst_rdata", axi_rdata, 0);
    chk("rst_resps", {axi_rresp, axi_bresp}, 0);
    chk("rst_rd_cnt", rd_cnt, 0);
    chk("rst_wr_cnt", wr_cnt, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("release_readies_lo", {axi_arready, axi_awready, axi_wready}, 3'b000);
    @(negedge clk);
    chk("release_readies_hi", {axi_arready, axi_awready, axi_wready}, 3'b111);
    @(posedge clk); #1;

    // Simultaneous AW/W full write then read back.
    do_write(32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 0, 0);
    wait_b(2'b00, 0);
    do_ar(32'h0000_0010);
    get_r(32'hDEAD_BEEF, 2'b00, 0);
    chk("wr_cnt_after_first", wr_cnt, exp_wr);
    chk("rd_cnt_after_first", rd_cnt, exp_rd);

    // W three cycles ahead of AW with a partial strobe.
    do_w(32'h1122_3344, 4'b0101);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("wready_while_w_got", axi_wready, 0);
      chk("no_bvalid_before_aw", axi_bvalid, 0);
      @(posedge clk); #1;
    end
    do_aw(32'h0000_0010);
    wait_b(2'b00, 0);
    do_ar(32'h0000_0010);
    get_r(32'hDE22_BE44, 2'b00, 0);

    // Out-of-range access aliases word 0 but must leave it untouched.
    do_write(32'h0000_0000, 32'hCAFE_F00D, 4'b1111, 0, 0);
    wait_b(2'b00, 0);
    do_write(32'h0000_1000, 32'h1234_5678, 4'b1111, 0, 0);
    wait_b(2'b10, 0);
    do_ar(32'h0000_1000);
    get_r(32'h0000_0000, 2'b10, 0);
    do_ar(32'h0000_0000);
    get_r(32'hCAFE_F00D, 2'b00, 0);

    // Backpressure on both response channels for five cycles.
    fork
      do_ar(32'h0000_0010);
      do_aw(32'h0000_0020);
      do_w(32'h5A5A_5A5A, 4'b1111);
    join
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rvalid", axi_rvalid, 1);
      chk("bp_rdata", axi_rdata, 32'hDE22_BE44);
      chk("bp_bvalid", axi_bvalid, 1);
      chk("bp_bresp", axi_bresp, 2'b00);
      chk("bp_readies", {axi_arready, axi_awready, axi_wready}, 3'b000);
      @(posedge clk); #1;
    end
    get_r(32'hDE22_BE44, 2'b00, 0);
    wait_b(2'b00, 0);
    do_ar(32'h0000_0020);
    get_r(32'h5A5A_5A5A, 2'b00, 0);
    chk("bp_wr_cnt", wr_cnt, exp_wr);
    chk("bp_rd_cnt", rd_cnt, exp_rd);

    // Reset between AW and W abandons the write.
    do_write(32'h0000_0030, 32'h0BAD_F00D, 4'b1111, 0, 0);
    wait_b(2'b00, 0);
    do_aw(32'h0000_0030);
    rst_n  = 1'b0;
    exp_rd = 0;
    exp_wr = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_mid_no_bvalid", axi_bvalid, 0);
      @(posedge clk); #1;
    end
    chk("rst_mid_wr_cnt", wr_cnt, 0);
    do_ar(32'h0000_0030);
    get_r(32'h0BAD_F00D, 2'b00, 0);
    chk("rst_mid_rd_cnt", rd_cnt, exp_rd);

    // Constant vector table.
    for (int t = 0; t < 7; t++) begin
      do_write(tbl[t].addr, tbl[t].init, 4'b1111, 0, 0);
      wait_b(tbl[t].exp_resp, 0);
      do_write(tbl[t].addr, tbl[t].data, tbl[t].strb, t % 3, t % 2);
      wait_b(tbl[t].exp_resp, 0);
      do_ar(tbl[t].addr);
      get_r(tbl[t].exp_rdata, tbl[t].exp_resp, 0);
    end

    // Randomized traffic over words 0..31 plus out-of-range addresses.
    for (int w = 0; w < 32; w++) begin
      data = $urandom;
      do_write(32'(w * 4), data, 4'b1111, 0, 0);
      wait_b(2'b00, 0);
      ref_mem[w] = data;
    end
    for (int n = 0; n < 150; n++) begin
      idx  = $urandom_range(0, 31);
      addr = 32'(idx * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) addr = addr + (32'h1 << $urandom_range(12, 31));
      inr = (addr < 32'h0000_1000);
      if ($urandom_range(0, 1) == 0) begin
        data = $urandom;
        strb = 4'($urandom_range(0, 15));
        do_write(addr, data, strb, $urandom_range(0, 2), $urandom_range(0, 3));
        wait_b(inr ? 2'b00 : 2'b10, $urandom_range(0, 3));
        if (inr) begin
          for (int b = 0; b < 4; b++) begin
            if (strb[b]) ref_mem[idx][8*b +: 8] = data[8*b +: 8];
          end
        end
      end else begin
        do_ar(addr);
        get_r(inr ? ref_mem[idx] : 32'h0000_0000, inr ? 2'b00 : 2'b10, $urandom_range(0, 3));
      end
    end
    chk("final_wr_cnt", wr_cnt, exp_wr);
    chk("final_rd_cnt", rd_cnt, exp_rd);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
